// File: rtl/p251_inv.sv
// GF(251) inverse via Fermat a^249, one square-and-multiply op per clock.
// Optional o_zero output enabled by P251_INV_ZERO_FLAG_EN.
module p251_inv (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_start,
  input  logic [7:0] i_a,
  output logic [7:0] o_c,
  output logic       o_done,
  output logic       o_busy
`ifdef P251_INV_ZERO_FLAG_EN
  ,
  output logic       o_zero
`endif
);

  localparam logic [7:0] EXP = 8'd249;

  typedef enum logic [1:0] {
    IDLE,
    SQR,
    MUL
  } state_t;

  state_t     state, state_nx;
  logic [7:0] r, r_nx;
  logic [7:0] b, b_nx;
  logic [2:0] idx, idx_nx;
  logic [7:0] c_nx;
  logic       done_nx;
  logic       busy_nx;
  logic [7:0] prod;

  // 262 rounds 2^16/251 up, so q can overshoot by one; t then goes negative
  function automatic logic [7:0] mod_mul(input logic [7:0] x,
                                         input logic [7:0] y);
    logic [15:0] p;
    logic [25:0] pq;
    logic [9:0]  q;
    logic [16:0] qm;
    logic [9:0]  t;
    p  = 16'(x) * 16'(y);
    pq = 26'(p) * 26'd262;
    q  = 10'(pq >> 16);
    qm = 17'(q) * 17'd251;
    t  = 10'(17'(p) - qm);
    if (t[9])
      t = t + 10'd251;
    else if (t >= 10'd251)
      t = t - 10'd251;
    return 8'(t);
  endfunction

  assign prod = mod_mul(r, (state == MUL) ? b : r);

  always_comb begin
    state_nx = state;
    r_nx     = r;
    b_nx     = b;
    idx_nx   = idx;
    c_nx     = o_c;
    done_nx  = 1'b0;
    busy_nx  = o_busy;
    unique case (state)
      IDLE: begin
        // a start coincident with o_done is dropped
        if (i_start && !o_done) begin
          b_nx     = (i_a >= 8'd251) ? i_a - 8'd251 : i_a;
          r_nx     = b_nx;
          idx_nx   = 3'd6;
          busy_nx  = 1'b1;
          state_nx = SQR;
        end
      end
      SQR: begin
        r_nx = prod;
        if (EXP[idx]) begin
          state_nx = MUL;
        end else if (idx == 3'd0) begin
          c_nx     = prod;
          done_nx  = 1'b1;
          busy_nx  = 1'b0;
          state_nx = IDLE;
        end else begin
          idx_nx = idx - 3'd1;
        end
      end
      MUL: begin
        r_nx = prod;
        if (idx == 3'd0) begin
          c_nx     = prod;
          done_nx  = 1'b1;
          busy_nx  = 1'b0;
          state_nx = IDLE;
        end else begin
          idx_nx   = idx - 3'd1;
          state_nx = SQR;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state  <= IDLE;
      r      <= '0;
      b      <= '0;
      idx    <= '0;
      o_c    <= '0;
      o_done <= 1'b0;
      o_busy <= 1'b0;
    end else begin
      state  <= state_nx;
      r      <= r_nx;
      b      <= b_nx;
      idx    <= idx_nx;
      o_c    <= c_nx;
      o_done <= done_nx;
      o_busy <= busy_nx;
    end
  end

`ifdef P251_INV_ZERO_FLAG_EN
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)
      o_zero <= 1'b0;
    else if (done_nx)
      o_zero <= (b == 8'd0);
  end
`endif

endmodule

// File: tb/tb_p251_inv.sv
// Bench for p251_inv: table vectors, sweep, random, and corner sequences.
// Checks o_zero as well when P251_INV_ZERO_FLAG_EN is defined.
module tb_p251_inv;

  logic       i_clk;
  logic       i_rst_n;
  logic       i_start;
  logic [7:0] i_a;
  logic [7:0] o_c;
  logic       o_done;
  logic       o_busy;
`ifdef P251_INV_ZERO_FLAG_EN
  logic       o_zero;
`endif

  int errors = 0;
  int checks = 0;

  p251_inv dut (
    .i_clk  (i_clk),
    .i_rst_n(i_rst_n),
    .i_start(i_start),
    .i_a    (i_a),
    .o_c    (o_c),
    .o_done (o_done),
    .o_busy (o_busy)
`ifdef P251_INV_ZERO_FLAG_EN
    ,
    .o_zero (o_zero)
`endif
  );

  initial begin
    i_clk = 1'b0;
    forever #5 i_clk = ~i_clk;
  end

  typedef struct {
    logic [7:0] a;
    logic [7:0] c;
  } vec_t;

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // field inverse by exhaustive search over GF(251)
  function automatic int ref_inv(input int a);
    int bb;
    bb = a % 251;
    for (int x = 1; x < 251; x++)
      if ((bb * x) % 251 == 1) return x;
    return 0;
  endfunction

  task automatic run_op(input logic [7:0] a, input int exp_c,
                        input string nm, output int c);
    int n;
    bit got;
    bit bz;
    i_a = a;
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
    n = 0;
    got = 0;
    bz = 1;
    while (!got && n < 30) begin
      if (!o_busy) bz = 0;
      tick();
      n++;
      if (o_done) got = 1;
    end
    c = int'(o_c);
    chk({nm, " latency"}, n, 12);
    chk({nm, " busy"}, int'(bz), 1);
    chk({nm, " c"}, int'(o_c), exp_c);
    chk({nm, " busy_fall"}, int'(o_busy), 0);
`ifdef P251_INV_ZERO_FLAG_EN
    chk({nm, " zero"}, int'(o_zero), (int'(a) % 251 == 0) ? 1 : 0);
`endif
    tick();
    chk({nm, " pulse"}, int'(o_done), 0);
    chk({nm, " hold"}, int'(o_c), exp_c);
  endtask

  vec_t vecs[8];
  int   c;
  int   a;
  bit   ok;
  int   dn;

  initial begin
    vecs[0] = '{8'd2,   8'd126};
    vecs[1] = '{8'd3,   8'd84};
    vecs[2] = '{8'd250, 8'd250};
    vecs[3] = '{8'd1,   8'd1};
    vecs[4] = '{8'd253, 8'd126};
    vecs[5] = '{8'd0,   8'd0};
    vecs[6] = '{8'd251, 8'd0};
    vecs[7] = '{8'd255, 8'd63};

    i_rst_n = 1'b0;
    i_start = 1'b0;
    i_a = '0;
    tick();
    chk("reset c", int'(o_c), 0);
    chk("reset done", int'(o_done), 0);
    chk("reset busy", int'(o_busy), 0);
`ifdef P251_INV_ZERO_FLAG_EN
    chk("reset zero", int'(o_zero), 0);
`endif
    tick();
    i_rst_n = 1'b1;
    tick();

    for (int i = 0; i < 8; i++)
      run_op(vecs[i].a, int'(vecs[i].c), $sformatf("vec%0d", i), c);

    for (int k = 1; k <= 250; k++) begin
      run_op(8'(k), ref_inv(k), $sformatf("sweep%0d", k), c);
      chk($sformatf("sweep%0d prod", k), (k * c) % 251, 1);
    end

    for (int k = 0; k < 40; k++) begin
      a = int'($urandom_range(0, 255));
      run_op(8'(a), ref_inv(a), $sformatf("rand a=%0d", a), c);
    end

    // starts during busy and during the done cycle must be ignored
    i_a = 8'd2;
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
    dn = 0;
    ok = 1;
    for (int k = 1; k <= 12; k++) begin
      if (k == 5) begin
        i_a = 8'd3;
        i_start = 1'b1;
      end
      tick();
      i_start = 1'b0;
      if (o_done) begin
        dn++;
        if (k != 12) ok = 0;
      end
    end
    chk("ign done count", dn, 1);
    chk("ign done time", int'(ok), 1);
    chk("ign c", int'(o_c), 126);
    i_a = 8'd3;
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
    chk("ign busy after", int'(o_busy), 0);
    dn = 0;
    for (int k = 0; k < 16; k++) begin
      tick();
      if (o_done || o_c != 8'd126) dn++;
    end
    chk("ign no second op", dn, 0);

    // reset mid-operation
    i_a = 8'd3;
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
    for (int k = 0; k < 6; k++) tick();
    i_rst_n = 1'b0;
    #1;
    chk("abort c", int'(o_c), 0);
    chk("abort done", int'(o_done), 0);
    chk("abort busy", int'(o_busy), 0);
    tick();
    i_rst_n = 1'b1;
    dn = 0;
    for (int k = 0; k < 15; k++) begin
      tick();
      if (o_done || o_busy) dn++;
    end
    chk("abort quiet", dn, 0);
    run_op(8'd250, 250, "after abort", c);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
